gl_bram_port_arbiter: RTL

- Shares the single 32-bit BRAM A port of the GL core among NUM_REQ internal requesters, e.g. command fetch, vertex fetch and framebuffer writer.
- Arbitration is round-robin, one access per cycle, with reads pipelined through a tag shift register.
- Read data returns in order to the issuing requester.
- Sits between the core's internal masters and the BRAM port signals (en, write_en, addr, write data, read data).

---
 rtl/gl_bram_port_arbiter_if.sv | 34 +++
 rtl/gl_bram_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gl_bram_port_arbiter_if.sv
// rtl/gl_bram_port_arbiter_if.sv - requester and BRAM port signal bundle for gl_bram_port_arbiter
interface gl_bram_port_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 32
);
   // requester side
   logic [NUM_REQ-1:0]        req_valid;
   logic [4*NUM_REQ-1:0]      req_we;
   logic [ADDR_W*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0]     req_wdata;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [31:0]               rsp_data;

   // BRAM A port side
   logic                      bram_en;
   logic [3:0]                bram_we;
   logic [ADDR_W-1:0]         bram_addr;
   logic [31:0]               bram_wdata;
   logic [31:0]               bram_rdata;

   // environment view: requesters and the BRAM itself
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_lock, bram_rdata,
      input  req_ready, rsp_valid, rsp_data, bram_en, bram_we, bram_addr, bram_wdata
   );

   // arbiter view
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_lock, bram_rdata,
      output req_ready, rsp_valid, rsp_data, bram_en, bram_we, bram_addr, bram_wdata
   );
endinterface

// File: rtl/gl_bram_port_arbiter.sv
// rtl/gl_bram_port_arbiter.sv - round-robin arbiter sharing one BRAM port; GL_ARB_LOCK_EN enables grant locking
module gl_bram_port_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int ADDR_W   = 32,
   parameter int BRAM_LAT = 1,
   parameter int MAX_LOCK = 8
) (
   input logic                   clk,
   input logic                   reset_n,
   gl_bram_port_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  ptr_inc;
   logic [IDX_W-1:0]  next_ptr;
   logic [IDX_W-1:0]  grant_idx;
   logic [NUM_REQ-1:0] grant_oh;
   logic              grant_any;
   logic [IDX_W:0]    scan_sum;
   logic [IDX_W-1:0]  scan_idx;

   logic [3:0]        grant_we;
   logic [ADDR_W-1:0] grant_addr;
   logic [31:0]       grant_wdata;
   logic              push_read;

   // read tags travel alongside the BRAM access so data can be routed back in order
   logic              tag_v [BRAM_LAT];
   logic [IDX_W-1:0]  tag_g [BRAM_LAT];

   // scan from the pointer and pick the first valid requester
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (scan_sum >= (IDX_W+1)'(NUM_REQ))
            scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
         scan_idx = scan_sum[IDX_W-1:0];
         if (!grant_any && reset_n && bus.req_valid[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
      if (grant_any)
         grant_oh[grant_idx] = 1'b1;
   end

   assign bus.req_ready = grant_oh;

   // select the granted requester's beat
   always_comb begin
      grant_we    = '0;
      grant_addr  = '0;
      grant_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            grant_we    = bus.req_we[4*i +: 4];
            grant_addr  = bus.req_addr[ADDR_W*i +: ADDR_W];
            grant_wdata = bus.req_wdata[32*i +: 32];
         end
      end
   end

   assign push_read = grant_any && (grant_we == 4'h0);
   assign ptr_inc   = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

`ifdef GL_ARB_LOCK_EN
   localparam int CNT_W = $clog2(MAX_LOCK+1);

   logic [CNT_W-1:0] lock_cnt;
   logic [CNT_W-1:0] lock_base;
   logic [CNT_W-1:0] lock_cnt_nxt;

   // a locked grant keeps priority until MAX_LOCK consecutive locked grants have gone out
   always_comb begin
      next_ptr     = ptr_inc;
      lock_cnt_nxt = lock_cnt;
      lock_base    = '0;
      if (grant_any) begin
         if (|(grant_oh & bus.req_lock)) begin
            // while locked the pointer sits on the holder, so a grant elsewhere restarts the run
            lock_base = (grant_idx == ptr) ? lock_cnt : '0;
            if (lock_base == CNT_W'(MAX_LOCK-1)) begin
               lock_cnt_nxt = '0;
               next_ptr     = ptr_inc;
            end else begin
               lock_cnt_nxt = lock_base + 1'b1;
               next_ptr     = grant_idx;
            end
         end else begin
            lock_cnt_nxt = '0;
         end
      end
   end

   // lock run length
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         lock_cnt <= '0;
      else
         lock_cnt <= lock_cnt_nxt;
   end
`else
   logic unused_lock;
   assign unused_lock = ^bus.req_lock;

   // pure round-robin: always move past the granted requester
   always_comb begin
      next_ptr = ptr_inc;
   end
`endif

   // round-robin pointer advances only on a handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr <= '0;
      else if (grant_any)
         ptr <= next_ptr;
   end

   // register the granted beat onto the BRAM port; address and data hold when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.bram_en    <= 1'b0;
         bus.bram_we    <= 4'h0;
         bus.bram_addr  <= '0;
         bus.bram_wdata <= '0;
      end else if (grant_any) begin
         bus.bram_en    <= 1'b1;
         bus.bram_we    <= grant_we;
         bus.bram_addr  <= grant_addr;
         bus.bram_wdata <= grant_wdata;
      end else begin
         bus.bram_en    <= 1'b0;
         bus.bram_we    <= 4'h0;
      end
   end

   // shift read tags in lockstep with the BRAM read latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < BRAM_LAT; s++) begin
            tag_v[s] <= 1'b0;
            tag_g[s] <= '0;
         end
      end else begin
         tag_v[0] <= push_read;
         tag_g[0] <= grant_idx;
         for (int s = 1; s < BRAM_LAT; s++) begin
            tag_v[s] <= tag_v[s-1];
            tag_g[s] <= tag_g[s-1];
         end
      end
   end

   // retire the oldest tag: strobe its requester and capture the BRAM data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            bus.rsp_valid[i] <= tag_v[BRAM_LAT-1] && (tag_g[BRAM_LAT-1] == IDX_W'(i));
         if (tag_v[BRAM_LAT-1])
            bus.rsp_data <= bus.bram_rdata;
      end
   end
endmodule
